// File: rtl/spi_reg_arbiter.sv
// Two-requester round-robin arbiter feeding a 16-bit SPI mode-0 master for
// MAX3421E register access: one command byte plus one data byte per access.
module spi_reg_arbiter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_write,
    input  logic [4:0] req0_addr,
    input  logic [7:0] req0_wdata,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_write,
    input  logic [4:0] req1_addr,
    input  logic [7:0] req1_wdata,

    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_status,
    output logic [7:0] rsp_rdata,
    output logic       busy,

    output logic       spi0_SCLK,
    output logic       spi0_MOSI,
    input  logic       spi0_MISO,
    output logic       spi0_SS_n
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 4;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                ss_n_q, ss_n_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   tx_q, tx_d;
    logic [WORD_W-1:0]   rx_q, rx_d;
    logic                id_q, id_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_status_q, rsp_status_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                hs0_c;
    logic                hs1_c;

    // Shift word: {addr, 0, write, 0} command byte, then write data or zero.
    function automatic logic [WORD_W-1:0] build_word(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] cmd;
        logic [DATA_W-1:0] data;
        cmd  = {addr, 1'b0, wr, 1'b0};
        data = wr ? wdata : DATA_W'(0);
        return {cmd, data};
    endfunction

    // Round-robin pick; with nobody waiting the pointer rests on the other side.
    function automatic logic arbitrate(
        input logic v0,
        input logic v1,
        input logic last
    );
        logic g;
        if (v0 && v1) begin
            g = ~last;
        end else if (v0) begin
            g = 1'b0;
        end else if (v1) begin
            g = 1'b1;
        end else begin
            g = ~last;
        end
        return g;
    endfunction

    // Readiness depends only on FSM state and the registered grant.
    always_comb begin
        req0_ready = ~reset_reset && (state_q == IDLE) && ~grant_q;
        req1_ready = ~reset_reset && (state_q == IDLE) &&  grant_q;
        hs0_c      = req0_valid && req0_ready;
        hs1_c      = req1_valid && req1_ready;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            ss_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            tx_q         <= '0;
            rx_q         <= '0;
            id_q         <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_status_q <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            ss_n_q       <= ss_n_d;
            busy_q       <= busy_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            id_q         <= id_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_status_q <= rsp_status_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sclk_d       = sclk_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        id_d         = id_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_status_d = rsp_status_q;
        rsp_rdata_d  = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (hs0_c || hs1_c) begin
                    state_d      = SETUP;
                    cnt_d        = '0;
                    bit_d        = '0;
                    sclk_d       = 1'b0;
                    id_d         = hs1_c;
                    last_grant_d = hs1_c;
                    tx_d         = hs1_c ? build_word(req1_write, req1_addr, req1_wdata)
                                         : build_word(req0_write, req0_addr, req0_wdata);
                end
            end
            SETUP: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // Sample MISO as SCLK rises; advance MOSI as SCLK falls.
                if (cnt_q == CNT_MAX) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[WORD_W-2:0], spi0_MISO};
                    end else begin
                        tx_d  = {tx_q[WORD_W-2:0], 1'b0};
                        bit_d = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CNT_MAX) begin
                    state_d      = GAP;
                    cnt_d        = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_status_d = rx_q[WORD_W-1:DATA_W];
                    rsp_rdata_d  = rx_q[DATA_W-1:0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grant moves only on edges that land in IDLE, so it is stable for ready.
        if (state_d == IDLE) begin
            grant_d = arbitrate(req0_valid, req1_valid, last_grant_d);
        end
    end

    always_comb begin
        ss_n_d = ~((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        busy_d = (state_d != IDLE);
        mosi_d = tx_d[WORD_W-1];
    end

    assign spi0_SCLK  = sclk_q;
    assign spi0_MOSI  = mosi_q;
    assign spi0_SS_n  = ss_n_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_status = rsp_status_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Bench for spi_reg_arbiter: table of register accesses against a behavioural
// SPI slave, scoreboarded responses, plus reset-abort, back-to-back and CLK_DIV=2 runs.
module tb_spi_reg_arbiter;

    localparam int unsigned CLK_DIV = 4;
    localparam int          LAT     = 137;
    localparam int          SS_LOW  = 136;
    localparam int          GAP_HI  = 5;
    localparam int          LAT2    = 69;

    typedef struct {
        logic        id;
        logic        write;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] miso;
        logic [15:0] exp_mosi;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] exp_mosi;
        logic [7:0]  exp_status;
        logic [7:0]  exp_rdata;
        int          due;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_write;
    logic [4:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       req1_valid, req1_ready, req1_write;
    logic [4:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp_valid, rsp_id, busy;
    logic [7:0] rsp_status, rsp_rdata;
    logic       sclk, mosi, miso, ss_n;

    logic       d2_req0_valid, d2_req0_ready, d2_req1_valid, d2_req1_ready;
    logic       d2_rsp_valid, d2_rsp_id, d2_busy;
    logic [7:0] d2_rsp_status, d2_rsp_rdata;
    logic       d2_sclk, d2_mosi, d2_miso, d2_ss_n;

    vec_t        vecs[6];
    vec_t        by_id[2];
    vec_t        rst_vec;
    sb_t         sb[$];
    logic        hs_ids[$];
    int          hs_count = 0;
    int          rsp_count = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic        sclk_prev = 1'b0;
    logic        ss_prev = 1'b1;
    logic [15:0] mosi_cap = '0;
    logic [15:0] miso_sh = '0;
    int          rise_cnt = 0;
    int          ss_low = 0;
    int          ss_hi_run = 0;
    logic        chk_gap = 1'b0;
    logic        b15_pend = 1'b0;
    logic        b15_exp = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_arbiter #(.CLK_DIV(CLK_DIV)) dut (
        .clk_clk(clk), .reset_reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_status(rsp_status),
        .rsp_rdata(rsp_rdata), .busy(busy),
        .spi0_SCLK(sclk), .spi0_MOSI(mosi), .spi0_MISO(miso), .spi0_SS_n(ss_n)
    );

    spi_reg_arbiter #(.CLK_DIV(2)) dut2 (
        .clk_clk(clk), .reset_reset(reset),
        .req0_valid(d2_req0_valid), .req0_ready(d2_req0_ready), .req0_write(1'b0),
        .req0_addr(5'h05), .req0_wdata(8'h00),
        .req1_valid(d2_req1_valid), .req1_ready(d2_req1_ready), .req1_write(1'b0),
        .req1_addr(5'h00), .req1_wdata(8'h00),
        .rsp_valid(d2_rsp_valid), .rsp_id(d2_rsp_id), .rsp_status(d2_rsp_status),
        .rsp_rdata(d2_rsp_rdata), .busy(d2_busy),
        .spi0_SCLK(d2_sclk), .spi0_MOSI(d2_mosi), .spi0_MISO(d2_miso), .spi0_SS_n(d2_ss_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model, handshake monitor and response scoreboard, all on the falling edge.
    always @(negedge clk) begin : mon
        sb_t  e;
        logic hid;
        logic hs;
        if (b15_pend) begin
            check("ss_fall_t1", 32'(ss_n), 32'(0));
            check("mosi_bit15", 32'(mosi), 32'(b15_exp));
            b15_pend = 1'b0;
        end
        hs  = !reset && ((req0_valid && req0_ready) || (req1_valid && req1_ready));
        hid = req1_valid && req1_ready;
        if (hs) begin
            e.id         = hid;
            e.exp_mosi   = by_id[hid].exp_mosi;
            e.exp_status = by_id[hid].miso[15:8];
            e.exp_rdata  = by_id[hid].miso[7:0];
            e.due        = cyc + LAT;
            sb.push_back(e);
            hs_ids.push_back(hid);
            hs_count++;
            miso_sh  = by_id[hid].miso;
            miso     = miso_sh[15];
            rise_cnt = 0;
            ss_low   = 0;
            mosi_cap = '0;
            b15_pend = 1'b1;
            b15_exp  = by_id[hid].exp_mosi[15];
        end
        if (sclk && !sclk_prev) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[14:0], mosi};
        end
        if (!sclk && sclk_prev) begin
            miso_sh = miso_sh << 1;
            miso    = miso_sh[15];
        end
        if (!ss_n) ss_low++;
        if (chk_gap && !ss_n && ss_prev) check("ss_high_gap", 32'(ss_hi_run), 32'(GAP_HI));
        ss_hi_run = ss_n ? ss_hi_run + 1 : 0;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 with id %0d, expected none", rsp_id);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_status", 32'(rsp_status), 32'(e.exp_status));
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.exp_rdata));
                check("rsp_latency", 32'(cyc), 32'(e.due));
                check("mosi_word", 32'(mosi_cap), 32'(e.exp_mosi));
                check("sclk_rises", 32'(rise_cnt), 32'(16));
                check("ss_low_len", 32'(ss_low), 32'(SS_LOW));
                check("ss_high_at_rsp", 32'(ss_n), 32'(1));
                rsp_count++;
            end
        end
        sclk_prev = sclk;
        ss_prev   = ss_n;
    end

    task automatic drive(input vec_t v);
        by_id[v.id] = v;
        if (v.id == 1'b0) begin
            req0_write = v.write; req0_addr = v.addr; req0_wdata = v.wdata; req0_valid = 1'b1;
        end else begin
            req1_write = v.write; req1_addr = v.addr; req1_wdata = v.wdata; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("handshake_seen", 32'(hs_count >= target), 32'(1));
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (rsp_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("response_seen", 32'(rsp_count >= target), 32'(1));
    endtask

    task automatic run_vec(input vec_t v);
        int hb;
        int rb;
        @(posedge clk); #1;
        hb = hs_count;
        rb = rsp_count;
        drive(v);
        wait_hs(hb + 1, 50);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(rb + 1, 200);
        repeat (8) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   hb;
        int   rb;
        int   t0;
        int   n;
        int   lat;
        int   hi_run;
        int   lo_run;
        int   rises;
        int   bad;
        logic prev;
        logic got;

        vecs[0] = '{id:1'b0, write:1'b0, addr:5'h12, wdata:8'h77, miso:16'hA53C, exp_mosi:16'h9000};
        vecs[1] = '{id:1'b1, write:1'b1, addr:5'h0D, wdata:8'h81, miso:16'h5AC3, exp_mosi:16'h6A81};
        vecs[2] = '{id:1'b0, write:1'b1, addr:5'h1F, wdata:8'hFF, miso:16'h00FF, exp_mosi:16'hFAFF};
        vecs[3] = '{id:1'b1, write:1'b0, addr:5'h00, wdata:8'hAA, miso:16'hFF00, exp_mosi:16'h0000};
        vecs[4] = '{id:1'b0, write:1'b1, addr:5'h01, wdata:8'h55, miso:16'h817E, exp_mosi:16'h0A55};
        vecs[5] = '{id:1'b1, write:1'b0, addr:5'h10, wdata:8'h00, miso:16'h3CA5, exp_mosi:16'h8000};
        rst_vec = '{id:1'b1, write:1'b0, addr:5'h03, wdata:8'h00, miso:16'h0F0F, exp_mosi:16'h1800};

        reset = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        d2_req0_valid = 1'b0; d2_req1_valid = 1'b0; d2_miso = 1'b1;
        miso = 1'b0;
        by_id[0] = vecs[0];
        by_id[1] = vecs[1];

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ss_n", 32'(ss_n), 32'(1));
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_status", 32'(rsp_status), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_ready0", 32'(req0_ready), 32'(0));
        check("rst_ready1", 32'(req1_ready), 32'(0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_ready0_no_valid", 32'(req0_ready), 32'(1));
        check("idle_ready1_no_valid", 32'(req1_ready), 32'(0));

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        @(negedge clk);
        check("rsp_id_held", 32'(rsp_id), 32'(vecs[5].id));
        check("rsp_rdata_held", 32'(rsp_rdata), 32'(vecs[5].miso[7:0]));
        check("rsp_status_held", 32'(rsp_status), 32'(vecs[5].miso[15:8]));

        // Requester 1 pulses valid while grant points at 0, then withdraws.
        @(posedge clk); #1;
        hb = hs_count;
        req1_write = 1'b1; req1_addr = 5'h07; req1_wdata = 8'h11; req1_valid = 1'b1;
        @(negedge clk);
        check("ready1_not_granted", 32'(req1_ready), 32'(0));
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (10) @(posedge clk);
        check("withdrawn_no_handshake", 32'(hs_count), 32'(hb));
        @(negedge clk);
        check("withdrawn_not_busy", 32'(busy), 32'(0));

        // Inputs change one cycle after the handshake; MOSI must not follow.
        @(posedge clk); #1;
        hb = hs_count;
        rb = rsp_count;
        drive(vecs[0]);
        wait_hs(hb + 1, 50);
        #1 req0_addr = 5'h1F; req0_wdata = 8'hFF; req0_write = 1'b1; req0_valid = 1'b0;
        wait_rsp(rb + 1, 200);
        repeat (8) @(posedge clk);

        // Reset during bit 7 of the shift aborts the access.
        @(posedge clk); #1;
        hb = hs_count;
        drive(rst_vec);
        wait_hs(hb + 1, 50);
        #1 req1_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        rb = rsp_count;
        @(posedge clk);
        @(negedge clk);
        check("abort_ss_n", 32'(ss_n), 32'(1));
        check("abort_sclk", 32'(sclk), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("abort_ready0", 32'(req0_ready), 32'(0));
        check("abort_ready1", 32'(req1_ready), 32'(0));
        @(posedge clk); #1 reset = 1'b0;
        repeat (150) @(posedge clk);
        check("abort_no_rsp", 32'(rsp_count), 32'(rb));
        run_vec(vecs[1]);

        // Both requesters held valid after reset: grants alternate 0,1,0,1.
        pulse_reset();
        @(posedge clk); #1;
        hb = hs_count;
        rb = rsp_count;
        drive(vecs[0]);
        drive(vecs[1]);
        wait_hs(hb + 1, 50);
        repeat (2) @(posedge clk);
        #1 chk_gap = 1'b1;
        wait_hs(hb + 4, 700);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(rb + 4, 300);
        chk_gap = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (hs_ids.size() > hb + k) check("grant_order", 32'(hs_ids[hb + k]), 32'(k % 2));
            else check("grant_order_missing", 32'(hs_ids.size()), 32'(hb + 4));
        end

        // CLK_DIV=2 instance: single read with MISO held high.
        @(posedge clk); #1 d2_req0_valid = 1'b1;
        t0 = -1;
        n = 0;
        while (t0 < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (d2_req0_valid && d2_req0_ready) t0 = cyc;
        end
        check("d2_handshake", 32'(t0 >= 0), 32'(1));
        @(posedge clk); #1 d2_req0_valid = 1'b0;
        hi_run = 0; lo_run = 0; rises = 0; bad = 0; prev = 1'b0; got = 1'b0; lat = 0; n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (d2_sclk) begin
                if (!prev) begin
                    rises++;
                    if (rises > 1 && lo_run != 2) bad++;
                    hi_run = 0;
                end
                hi_run++;
            end else begin
                if (prev) begin
                    if (hi_run != 2) bad++;
                    lo_run = 0;
                end
                lo_run++;
            end
            prev = d2_sclk;
            if (d2_rsp_valid) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
        check("d2_rsp_seen", 32'(got), 32'(1));
        check("d2_latency", 32'(lat), 32'(LAT2));
        check("d2_sclk_rises", 32'(rises), 32'(16));
        check("d2_phase_errors", 32'(bad), 32'(0));
        check("d2_rsp_status", 32'(d2_rsp_status), 32'(8'hFF));
        check("d2_rsp_rdata", 32'(d2_rsp_rdata), 32'(8'hFF));
        check("d2_ss_n_at_rsp", 32'(d2_ss_n), 32'(1));

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
